imem_loader: RTL
================

# imem_loader

Boot-time writer for the fetch stage's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and drives the instruction memory write port (WriteData, WriteEnable, byte address) at consecutive word addresses from 0. Holds the processor (PC and pipeline) stalled until the image is fully written. Sits between the external boot link and the instruction memory write port, beside the PC.

## Interface

- MEM_DEPTH, 256, instruction memory depth in 32-bit words; the largest accepted image.
- Clk  in  1  single system clock; all state updates on posedge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- WriteData  out  32  instruction word to instruction memory.
- WriteAddress  out  32  byte address (word index × 4).
- WriteEnable  out  1  one-cycle write strobe.
- CpuHold  out  1  stalls the PC and pipeline while high.
- Done  out  1  image fully written.
- Error  out  1  header word count exceeded MEM_DEPTH.

## Operation

- A byte is accepted on a rising edge where ByteValid && ByteReady are both high. Bytes are big-endian: the first byte of each group of four goes to bits [31:24].
- Stream format: a 4-byte header holding word count N, then N instruction words.
- FSM states: IDLE, HEADER, LOAD, DONE, ERROR.
  - IDLE: reset state. Start → HEADER.
  - HEADER: ByteReady=1. On the 4th accepted byte, latch N:
    - N > MEM_DEPTH → ERROR.
    - N == 0 → DONE.
    - Otherwise → LOAD, with the word index cleared to 0.
  - LOAD: ByteReady=1. On each 4th accepted byte, register the word and issue one write. After write N is issued → DONE.
  - DONE: Done=1, CpuHold=0. Start → HEADER (reload; CpuHold reasserts).
  - ERROR: Error=1, CpuHold=1, no writes. Start → HEADER.
- ByteReady=0 in IDLE, DONE and ERROR.
- Start is ignored in HEADER and LOAD.
- Byte lane counter: 2 bits, wraps 3→0. Word index: width clog2(MEM_DEPTH)+1. WriteAddress = {index, 2'b00}, zero-extended to 32 bits.
- Reset values: ByteReady=0, WriteData=0, WriteAddress=0, WriteEnable=0, CpuHold=1, Done=0, Error=0. The state is IDLE and all counters are 0.
- Reset mid-load: all state is cleared immediately. The partial word is discarded. Memory contents are left as written.

## Timing

- Writes are registered. If the 4th byte of word k is accepted at edge t:
  - WriteEnable=1 with WriteData and WriteAddress=4k during the cycle after t.
  - WriteEnable drops at edge t+1 unless another word completes at that same edge.
- ByteReady does not drop during a write. Back-to-back bytes give a sustained one write per 4 cycles.
- The FSM enters DONE at the edge after the last WriteEnable cycle. Done rises and CpuHold falls in the same cycle.
- For N == 0, DONE is entered at the edge after the 4th header byte is accepted.
- ERROR is entered at the edge after the 4th header byte is accepted.
- A ByteValid gap of any length mid-word preserves the lane count and the partial word.
- Start coincident with a byte in IDLE: the byte is not accepted, because ByteReady is still 0 in that cycle.

## Structure

- Package imem_loader_pkg: state enum (IDLE, HEADER, LOAD, DONE, ERROR), BYTES_PER_WORD=4, helper function for index width.
- Sub-module word_assembler: a shift register plus 2-bit lane counter. Takes byte/accept inputs and produces a word plus a one-cycle word_done. It is used for both the header and the instruction words.
- Top level holds the FSM, N register, word index and output registers.

## Test plan

- Reset: hold Rst_n=0 mid-stream. All outputs take their reset values, with CpuHold=1 and state IDLE. Then deassert reset and pulse Start: ByteReady=1 the next cycle.
- Two-word load, continuous stream 00 00 00 02, 02 32 40 20, 01 4B 68 22:
  - WriteEnable pulses twice: {0x02324020 @ 0x0} then {0x014B6822 @ 0x4}.
  - The pulses are 4 cycles apart.
  - Done=1 and CpuHold=0 the cycle after the second write.
- Stalled stream: the same image with ByteValid low for 5 cycles between bytes 2 and 3 of word 0. Writes are identical and no byte is lost.
- N=0 header: no WriteEnable is issued, and Done=1 the cycle after the 4th header byte. Header N=257 with MEM_DEPTH=256: Error=1, CpuHold stays 1, ByteReady=0, and no writes occur.
- Reload: Start in DONE, then a 1-word image 0x8D100000. CpuHold rises the next cycle, and one write {0x8D100000 @ 0x0} follows. A Start pulse during LOAD has no effect.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// State encoding and index-width helper for the boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOAD,
    DONE,
    ERROR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

  function automatic int idx_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler with a 2-bit lane counter.
// word_o is valid in the cycle word_done_o is high.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [23:0] sh_q, sh_d;
  logic [1:0]  lane_q, lane_d;

  localparam logic [1:0] LastLane = 2'(BYTES_PER_WORD - 1);

  always_comb begin
    sh_d   = sh_q;
    lane_d = lane_q;
    if (clr_i) begin
      sh_d   = '0;
      lane_d = '0;
    end else if (accept_i) begin
      sh_d   = {sh_q[15:0], byte_i};
      lane_d = lane_q + 2'd1;
    end
  end

  assign word_o      = {sh_q, byte_i};
  assign word_done_o = accept_i && !clr_i && (lane_q == LastLane);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      lane_q <= '0;
    end else begin
      sh_q   <= sh_d;
      lane_q <= lane_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: header word N, then N words
// written at consecutive word addresses while the CPU is held.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [31:0] WriteData,
  output logic [31:0] WriteAddress,
  output logic        WriteEnable,
  output logic        CpuHold,
  output logic        Done,
  output logic        Error
);

  localparam int IW = idx_width(MEM_DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   waddr_q, waddr_d;

  logic        clr;
  logic        accept;
  logic [31:0] word;
  logic        word_done;

  word_assembler u_asm (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .clr_i      (clr),
    .byte_i     (ByteIn),
    .accept_i   (accept),
    .word_o     (word),
    .word_done_o(word_done)
  );

  // Stop taking bytes once the last word is in flight.
  assign ByteReady = (state_q == HEADER)
                  || ((state_q == LOAD) && (idx_q != n_q));
  assign accept    = ByteValid && ByteReady;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          state_d = HEADER;
          idx_d   = '0;
          clr     = 1'b1;
        end
      end
      HEADER: begin
        if (word_done) begin
          if (word > 32'(MEM_DEPTH)) begin
            state_d = ERROR;
          end else if (word == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
            n_d     = word[IW-1:0];
            idx_d   = '0;
          end
        end
      end
      LOAD: begin
        if (word_done) begin
          we_d    = 1'b1;
          wdata_d = word;
          waddr_d = 32'({idx_q, 2'b00});
          idx_d   = idx_q + IW'(1);
        end else if (we_q && (idx_q == n_q)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
    end
  end

  assign WriteEnable  = we_q;
  assign WriteData    = wdata_q;
  assign WriteAddress = waddr_q;
  assign Done         = (state_q == DONE);
  assign Error        = (state_q == ERROR);
  assign CpuHold      = (state_q != DONE);

endmodule
